// File: rtl/dbg_mem_bridge.sv
// Debug memory bridge: serves command-processor reads and writes on a req/ack memory port
// while the CPU is halted, and keeps rdata current for the selected address.
module dbg_mem_bridge #(
    parameter int unsigned ADDR_W   = 30,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              rst_p,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic              wr_req,
    input  logic              sel_imem,
    input  logic              cpu_halt,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              wr_done,
    output logic              err,
    output logic              mem_own,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_imem,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, wr_addr_q, wr_addr_d;
    logic              sel_q, halt_q;
    logic              wr_sel_q, wr_sel_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              wr_pend_q, wr_pend_d;
    logic              discard_q, discard_d;
    logic [7:0]        cnt_q, cnt_d;

    logic [31:0]       rdata_d, mem_wdata_d;
    logic              valid_d, wr_done_d, err_d, mem_req_d, mem_we_d, mem_imem_d;
    logic [ADDR_W-1:0] mem_addr_d;

    logic [ADDR_W-1:0] addr_w;
    logic              chg, timed_out;
    logic              unused_addr;

    assign addr_w      = addr[ADDR_W+1:2];
    assign unused_addr = ^(addr >> (ADDR_W + 2)) ^ ^addr[1:0];
    assign mem_own     = cpu_halt;
    // Anything that makes the held rdata stale for the current request.
    assign chg         = (addr_w != addr_q) || (sel_imem != sel_q) || (halt_q && !cpu_halt);
    assign timed_out   = (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        wr_pend_d   = wr_pend_q;
        wr_addr_d   = wr_addr_q;
        wr_sel_d    = wr_sel_q;
        wr_data_d   = wr_data_q;
        discard_d   = discard_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata;
        valid_d     = rdata_valid;
        wr_done_d   = 1'b0;
        err_d       = err;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_imem_d  = mem_imem;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;

        if (chg) valid_d = 1'b0;

        if (wr_req && state_q != StWrite) begin
            wr_pend_d = 1'b1;
            wr_addr_d = addr_w;
            wr_sel_d  = sel_imem;
            wr_data_d = wdata;
        end

        case (state_q)
            StIdle: begin
                if (wr_pend_q) begin
                    if (cpu_halt) begin
                        state_d     = StWrite;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_imem_d  = wr_sel_d;
                        mem_addr_d  = wr_addr_d;
                        mem_wdata_d = wr_data_d;
                        cnt_d       = '0;
                    end else begin
                        wr_done_d = 1'b1;
                        err_d     = 1'b1;
                        valid_d   = 1'b0;
                        if (!wr_req) wr_pend_d = 1'b0;
                    end
                end else if (!rdata_valid) begin
                    if (cpu_halt) begin
                        state_d    = StRead;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_imem_d = sel_imem;
                        mem_addr_d = addr_w;
                        cnt_d      = '0;
                        discard_d  = 1'b0;
                    end else begin
                        err_d = 1'b1;
                        if (!chg) begin
                            rdata_d = ERR_WORD;
                            valid_d = 1'b1;
                        end
                    end
                end
            end
            StRead, StWrite: begin
                if (mem_ack || timed_out) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    err_d     = !mem_ack;
                    if (state_q == StWrite) begin
                        wr_done_d = 1'b1;
                        wr_pend_d = 1'b0;
                        valid_d   = 1'b0;
                    end else if (!discard_q && !chg && !wr_pend_d) begin
                        rdata_d = mem_ack ? mem_rdata : ERR_WORD;
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (chg) discard_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            sel_q       <= 1'b0;
            halt_q      <= 1'b0;
            wr_addr_q   <= '0;
            wr_sel_q    <= 1'b0;
            wr_data_q   <= '0;
            wr_pend_q   <= 1'b0;
            discard_q   <= 1'b0;
            cnt_q       <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            wr_done     <= 1'b0;
            err         <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_imem    <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_w;
            sel_q       <= sel_imem;
            halt_q      <= cpu_halt;
            wr_addr_q   <= wr_addr_d;
            wr_sel_q    <= wr_sel_d;
            wr_data_q   <= wr_data_d;
            wr_pend_q   <= wr_pend_d;
            discard_q   <= discard_d;
            cnt_q       <= cnt_d;
            rdata       <= rdata_d;
            rdata_valid <= valid_d;
            wr_done     <= wr_done_d;
            err         <= err_d;
            mem_req     <= mem_req_d;
            mem_we      <= mem_we_d;
            mem_imem    <= mem_imem_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_dbg_mem_bridge.sv
// Self-checking bench for dbg_mem_bridge: directed scenarios plus randomized reads/writes
// checked against a word-level memory model.
module tb_dbg_mem_bridge;

    localparam int unsigned AW   = 30;
    localparam int unsigned TMO  = 4;
    localparam logic [31:0] ERRW = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          rst_p, wr_req, sel_imem, cpu_halt;
    logic [31:0]   addr, wdata;
    logic [31:0]   rdata, mem_wdata;
    logic          rdata_valid, wr_done, err, mem_own, mem_req, mem_we, mem_imem;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [31:0]   mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    // Responder controls and statistics.
    int unsigned ack_delay = 0;
    bit          no_ack = 1'b0;
    bit          force_ack = 1'b0;
    int          req_cycles = 0;

    logic [31:0] mem [bit [30:0]];
    logic [31:0] exp_mem [bit [30:0]];

    dbg_mem_bridge #(
        .ADDR_W  (AW),
        .TIMEOUT (TMO),
        .ERR_WORD(ERRW)
    ) dut (
        .clk        (clk),
        .rst_p      (rst_p),
        .addr       (addr),
        .wdata      (wdata),
        .wr_req     (wr_req),
        .sel_imem   (sel_imem),
        .cpu_halt   (cpu_halt),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .wr_done    (wr_done),
        .err        (err),
        .mem_own    (mem_own),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_imem   (mem_imem),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic sel, input logic [29:0] w);
        if (!sel && w == 30'd4) return 32'h12345678;
        return ({2'b00, w} * 32'h9E3779B1) ^ (sel ? 32'hA5A50000 : 32'h00000000);
    endfunction

    function automatic logic [31:0] exp_read(input logic sel, input logic [29:0] w);
        if (exp_mem.exists({sel, w})) return exp_mem[{sel, w}];
        return init_word(sel, w);
    endfunction

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // which: 0 rdata_valid, 1 wr_done, 2 mem_req, 3 write in flight, 4 read in flight
    task automatic wait_sig(input string tag, input int which, input int max);
        bit hit = 1'b0;
        for (int i = 0; i < max && !hit; i++) begin
            @(negedge clk);
            case (which)
                0:       hit = rdata_valid;
                1:       hit = wr_done;
                2:       hit = mem_req;
                3:       hit = mem_req && mem_we;
                default: hit = mem_req && !mem_we;
            endcase
        end
        checks++;
        assert (hit) else begin
            errors++;
            $error("FAIL %s: observed no event expected event within %0d cycles", tag, max);
        end
    endtask

    // Memory responder: acts half a cycle after each rising edge, away from DUT sampling.
    initial begin
        int unsigned wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) req_cycles++;
            if (force_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'h55555555;
                wcnt      = 0;
            end else if (mem_req && !no_ack) begin
                if (wcnt == ack_delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) mem[{mem_imem, mem_addr}] = mem_wdata;
                    else if (mem.exists({mem_imem, mem_addr})) mem_rdata = mem[{mem_imem, mem_addr}];
                    else mem_rdata = init_word(mem_imem, mem_addr);
                    wcnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        bit          seen, hit;
        int          req_base;
        logic [29:0] w;
        logic        s;
        logic [31:0] d;
        int          op;

        rst_p = 1'b1; cpu_halt = 1'b1; addr = 32'h0C; wdata = '0; wr_req = 1'b0; sel_imem = 1'b0;
        repeat (2) @(negedge clk);
        check32("rst_rdata", rdata, 32'h0);
        check1("rst_valid", rdata_valid, 1'b0);
        check1("rst_wr_done", wr_done, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_mem_req", mem_req, 1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        check32("rst_mem_addr", {2'b00, mem_addr}, 32'h0);
        check1("rst_mem_own", mem_own, 1'b1);
        rst_p = 1'b0;
        wait_sig("init_valid", 0, 20);
        check32("init_rdata", rdata, exp_read(1'b0, 30'd3));

        // Zero-wait read: valid three cycles after the address change.
        addr = 32'h10;
        @(negedge clk);
        check1("t1_valid_drop", rdata_valid, 1'b0);
        @(negedge clk);
        check1("t1_mem_req", mem_req, 1'b1);
        check32("t1_mem_addr", {2'b00, mem_addr}, 32'h4);
        @(negedge clk);
        check1("t1_valid", rdata_valid, 1'b1);
        check32("t1_rdata", rdata, 32'h12345678);

        addr = 32'h14;
        @(negedge clk);
        check1("t2_valid_drop", rdata_valid, 1'b0);
        wait_sig("t2_valid", 0, 20);
        check32("t2_rdata", rdata, exp_read(1'b0, 30'd5));

        // Write to imem, then automatic re-read.
        addr = 32'h20; sel_imem = 1'b1; wdata = 32'hCAFEF00D; wr_req = 1'b1;
        exp_mem[{1'b1, 30'd8}] = 32'hCAFEF00D;
        @(negedge clk);
        wr_req = 1'b0;
        wait_sig("t3_wr_issue", 3, 20);
        check1("t3_mem_imem", mem_imem, 1'b1);
        check32("t3_mem_addr", {2'b00, mem_addr}, 32'h8);
        check32("t3_mem_wdata", mem_wdata, 32'hCAFEF00D);
        wait_sig("t3_wr_done", 1, 20);
        check1("t3_err", err, 1'b0);
        @(negedge clk);
        check1("t3_wr_done_pulse", wr_done, 1'b0);
        wait_sig("t3_reread", 0, 20);
        check32("t3_rdata", rdata, 32'hCAFEF00D);

        // Timeout on a memory that never acknowledges.
        no_ack = 1'b1; addr = 32'h30; sel_imem = 1'b0;
        wait_sig("t4_req", 2, 20);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!mem_req) break;
            n++;
        end
        check32("t4_req_cycles", n, 32'd4);
        check32("t4_rdata", rdata, ERRW);
        check1("t4_valid", rdata_valid, 1'b1);
        check1("t4_err", err, 1'b1);
        no_ack = 1'b0;

        // CPU running: everything is refused without touching the bus.
        req_base = req_cycles;
        cpu_halt = 1'b0;
        repeat (4) @(negedge clk);
        check1("t5_mem_own", mem_own, 1'b0);
        check32("t5_rdata", rdata, ERRW);
        check1("t5_valid", rdata_valid, 1'b1);
        check1("t5_err", err, 1'b1);
        addr = 32'h60; wdata = 32'h11111111; wr_req = 1'b1;
        @(negedge clk);
        wr_req = 1'b0;
        wait_sig("t5_wr_done", 1, 20);
        check1("t5_wr_err", err, 1'b1);
        repeat (3) @(negedge clk);
        check32("t5_no_bus", req_cycles - req_base, 32'd0);
        cpu_halt = 1'b1; addr = 32'h5C;
        wait_sig("t5_valid_a", 0, 20);
        addr = 32'h60;
        wait_sig("t5_valid_b", 0, 20);
        check32("t5_refused_no_effect", rdata, exp_read(1'b0, 30'd24));

        // Write request arriving during a slow read.
        ack_delay = 3; addr = 32'h40;
        wait_sig("t6_rd_issue", 4, 20);
        wdata = 32'h0BADC0DE; wr_req = 1'b1;
        exp_mem[{1'b0, 30'd16}] = 32'h0BADC0DE;
        @(negedge clk);
        wr_req = 1'b0;
        seen = 1'b0; hit = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (rdata_valid) seen = 1'b1;
            if (mem_req && mem_we) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check1("t6_write_issued", hit, 1'b1);
        check1("t6_read_discarded", seen, 1'b0);
        wait_sig("t6_wr_done", 1, 30);
        check1("t6_err", err, 1'b0);
        wait_sig("t6_reread", 0, 30);
        check32("t6_rdata", rdata, 32'h0BADC0DE);

        // Randomized reads and writes against the word model.
        for (int i = 0; i < 16; i++) begin
            w = 30'($urandom_range(0, 15));
            s = 1'($urandom_range(0, 1));
            op = $urandom_range(0, 2);
            ack_delay = $urandom_range(0, 3);
            addr = {w, 2'($urandom_range(0, 3))};
            sel_imem = s;
            if (op == 2) begin
                d = $urandom;
                wdata = d; wr_req = 1'b1;
                exp_mem[{s, w}] = d;
                @(negedge clk);
                wr_req = 1'b0;
                wait_sig("rnd_wr_done", 1, 40);
                check1("rnd_wr_err", err, 1'b0);
                wait_sig("rnd_wr_valid", 0, 40);
                check32("rnd_wr_rdback", rdata, d);
            end else begin
                wait_sig("rnd_rd_valid", 0, 40);
                check32("rnd_rd", rdata, exp_read(s, w));
            end
        end

        // Reset in the middle of an access; a late ack must be ignored.
        ack_delay = 0; no_ack = 1'b1; addr = 32'h50; sel_imem = 1'b0;
        wait_sig("t7_req", 2, 20);
        rst_p = 1'b1;
        @(negedge clk);
        check1("t7_mem_req", mem_req, 1'b0);
        check1("t7_valid", rdata_valid, 1'b0);
        check32("t7_rdata", rdata, 32'h0);
        check1("t7_err", err, 1'b0);
        check1("t7_mem_we", mem_we, 1'b0);
        check32("t7_mem_wdata", mem_wdata, 32'h0);
        force_ack = 1'b1;
        @(negedge clk);
        rst_p = 1'b0; force_ack = 1'b0; no_ack = 1'b0;
        @(negedge clk);
        check32("t7_late_ack_rdata", rdata, 32'h0);
        check1("t7_late_ack_valid", rdata_valid, 1'b0);
        check1("t7_late_ack_err", err, 1'b0);
        wait_sig("t7_reread", 0, 20);
        check32("t7_rdata_after", rdata, exp_read(1'b0, 30'd20));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbg_mem_bridge.md
# dbg_mem_bridge

Memory-access bridge between the UART debug command processor and the CPU's instruction/data memories. It accepts the processor's address, write data, write strobe and memory-space select. It performs word reads and writes on a req/ack memory port while the CPU is halted, and returns read data and write completion. Reads are autonomous: the bridge keeps `rdata` current for the selected address, so the command processor only waits on `rdata_valid`.

## Interface
- `ADDR_W`, 30: word-address width on the memory port.
- `TIMEOUT`, 255: cycles to wait for `mem_ack` before aborting an access (8-bit counter, range 1..255).
- `ERR_WORD`, 32'hDEADBEEF: data returned on an aborted or refused read.

Ports:
- `clk`  in  1  system clock.
- `rst_p`  in  1  reset. One clock; reset is synchronous and active-high.
- `addr`  in  32  byte address from the command processor. Bits [1:0] are ignored.
- `wdata`  in  32  write data.
- `wr_req`  in  1  write request pulse; may repeat while the processor waits.
- `sel_imem`  in  1  1 selects instruction memory, 0 selects data memory.
- `cpu_halt`  in  1  CPU is halted; memory access is permitted.
- `rdata`  out  32  read data for the current `addr`/`sel_imem`.
- `rdata_valid`  out  1  level; `rdata` matches the current address/space.
- `wr_done`  out  1  one-cycle pulse when a write finishes.
- `err`  out  1  last completed access was refused or timed out.
- `mem_own`  out  1  equals `cpu_halt`; steers the memory muxes to the bridge.
- `mem_req`  out  1  access request; held until ack or timeout.
- `mem_we`  out  1  1 = write.
- `mem_imem`  out  1  space of the access in flight.
- `mem_addr`  out  ADDR_W  `addr[ADDR_W+1:2]` captured at issue.
- `mem_wdata`  out  32  write data captured at issue.
- `mem_ack`  in  1  one-cycle completion; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  read data.

## Operation
- Registered copies `addr_q` and `sel_q` are loaded every cycle. A mismatch with the live inputs, or a falling `cpu_halt`, clears the fresh flag and `rdata_valid` in the next cycle.
- `wr_req` sets `wr_pend` and captures `wdata` and the address when the state is not WRITE. In WRITE, `wr_req` is ignored.
- Repeated writes of the same word are permitted and idempotent.
- States:
  - IDLE. Priority order:
    1. If `wr_pend`: go to WRITE when `cpu_halt`=1. Otherwise complete the write immediately as refused: `wr_done` pulse, `err`=1, no bus access.
    2. Else if not fresh: go to READ when `cpu_halt`=1. Otherwise load `rdata`=ERR_WORD, set `rdata_valid`=1 and `err`=1.
  - READ / WRITE. Drive `mem_req`=1 and clear the timeout counter. Leave on `mem_ack`, or when the counter reaches TIMEOUT (drop `mem_req`, `err`=1). Then return to IDLE.
- Read completion: load `rdata` from `mem_rdata`, or ERR_WORD on timeout, and set fresh/`rdata_valid`. This happens only if no address/space change and no `wr_pend` arose during the access. Otherwise the result is discarded and the state returns to IDLE to re-issue.
- Write completion: `wr_done` pulse, clear `wr_pend`, clear fresh. The following read then reflects the written value.
- `err` is updated on every completion: 0 on ack, 1 on refusal or timeout.
- `mem_ack` seen in IDLE is ignored.
- Reset: state IDLE. All outputs 0: `rdata`=0, `rdata_valid`=0, `wr_done`=0, `err`=0, `mem_req`=0, `mem_we`=0, `mem_imem`=0, `mem_addr`=0, `mem_wdata`=0. `wr_pend`=0, fresh=0. `mem_own` follows `cpu_halt` combinationally.
- Reset asserted mid-access drops `mem_req` at the next edge and discards the pending write.

## Timing
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` and `mem_imem` are registered. They assert one cycle after the IDLE decision and are stable until the cycle after ack or timeout.
- Ack-to-output latency is 1 cycle: `rdata`/`rdata_valid` or `wr_done` is high on the edge following `mem_ack`.
- Read latency from an address change with a zero-wait memory: change at edge N, detect N+1, IDLE decision N+2, `mem_req` N+2, ack N+2, `rdata_valid` N+3.
- Timeout: `mem_req` is high for exactly TIMEOUT cycles, then completion occurs at the next edge.
- Refused accesses (`cpu_halt`=0) complete 1 cycle after the IDLE decision.
- Minimum spacing between accesses is 1 IDLE cycle.
- `wr_req` arriving during READ is served immediately after that READ ends.

## Test plan
- Halted, zero-wait dmem model, `addr`=0x10 holding 0x12345678 → one read, `rdata`=0x12345678, `rdata_valid`=1 three cycles after the address change. Then `addr`=0x14 → `rdata_valid` drops within 2 cycles and re-asserts with the new word.
- Write: `wr_req` pulse with `wdata`=0xCAFEF00D, `addr`=0x20, `sel_imem`=1 → `mem_we`=1, `mem_imem`=1, `mem_addr`=0x8. One `wr_done` pulse, `err`=0. Then an automatic re-read gives `rdata`=0xCAFEF00D.
- Memory that never acks, TIMEOUT=4 → `mem_req` high for 4 cycles, then `rdata`=0xDEADBEEF, `rdata_valid`=1, `err`=1.
- `cpu_halt`=0 → `mem_req` never asserts. Read yields 0xDEADBEEF with `err`=1. `wr_req` yields a `wr_done` pulse with `err`=1.
- `wr_req` during an in-flight read with ack delayed 3 cycles → read data discarded (`rdata_valid` stays 0), write issued next, then re-read.
- `rst_p` asserted while `mem_req`=1 → `mem_req`=0 at the next edge, all outputs at reset values, and a late `mem_ack` is ignored.
